// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// encoding-length constants and PC step helper.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_FILL  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  // Low two bits of the first halfword that mark a full 32-bit encoding.
  localparam logic [1:0] RVC_LOW_BITS = 2'b11;

  localparam logic [2:0] INST_LEN_C = 3'd2;
  localparam logic [2:0] INST_LEN_W = 3'd4;

  function automatic logic [31:0] pc_step(input logic [31:0] pc, input logic [2:0] len);
    return pc + {29'd0, len};
  endfunction

endpackage

// File: rtl/ifetch_byte_asm.sv
// Collects instruction bytes from the memory arbiter, decides the encoding
// length from byte 0 and presents the assembled instruction for the cache write.
module ifetch_byte_asm
  import ifetch_unit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  input  logic        clear,
  input  logic        dvalid,
  input  logic [7:0]  din,
  output logic [2:0]  rcv,
  output logic [2:0]  need,
  output logic        last_byte,
  output logic [31:0] inst
);

  logic [7:0] byte_buf [4];
  logic [2:0] need_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    need_next = need;
    if (dvalid && (rcv == 3'd0))
      need_next = (din[1:0] == RVC_LOW_BITS) ? INST_LEN_W : INST_LEN_C;
  end

  // The length decision made by byte 0 already applies to the byte arriving with it.
  assign last_byte = dvalid && ((rcv + 3'd1) == need_next);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rcv  <= '0;
      need <= INST_LEN_C;
    end else if (en) begin
      if (clear) begin
        rcv  <= '0;
        need <= INST_LEN_C;
      end else if (dvalid) begin
        rcv  <= rcv + 3'd1;
        need <= need_next;
      end
    end
  end

  // NOTE: the byte buffer is pure data with no reset; it is only observed while the write strobe qualifies it.
  always_ff @(posedge clk_in) begin
    if (en && !clear && dvalid)
      byte_buf[rcv[1:0]] <= din;
  end

  assign inst = (need == INST_LEN_C) ? {16'h0000, byte_buf[1], byte_buf[0]}
                                     : {byte_buf[3], byte_buf[2], byte_buf[1], byte_buf[0]};

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, cache lookup, byte-wise miss refill and
// the valid/ready output register toward the decoder.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        icache_get_ready,
  output logic [31:0] icache_get_addr,
  input  logic        hit,
  input  logic [31:0] icache_get_inst,
  input  logic        icache_get_is_c,
  output logic        wr_ready,
  output logic        wr_is_c,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic        mem_dvalid,
  input  logic [7:0]  mem_din,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_is_c
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [2:0]   iss;
  logic         out_free, lookup_hit, lookup_miss, grant, dv, asm_clear, asm_last;
  logic [2:0]   asm_rcv, asm_need;
  logic [31:0]  asm_inst;

  assign out_free    = !inst_valid || inst_ready;
  assign lookup_hit  = icache_get_ready && hit;
  assign lookup_miss = icache_get_ready && !hit;
  assign grant       = mem_req && mem_grant;
  assign dv          = mem_dvalid && rdy_in && (state == S_MISS) && !flush_in;
  assign asm_clear   = flush_in || lookup_miss;

  ifetch_byte_asm u_byte_asm (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clear     (asm_clear),
    .dvalid    (dv),
    .din       (mem_din),
    .rcv       (asm_rcv),
    .need      (asm_need),
    .last_byte (asm_last),
    .inst      (asm_inst)
  );

  assign icache_get_addr = pc;
  assign mem_addr        = mem_req ? pc_step(pc, iss) : '0;
  assign wr_addr         = wr_ready ? pc : '0;
  assign wr_inst         = wr_ready ? asm_inst : '0;
  assign wr_is_c         = wr_ready && (asm_need == INST_LEN_C);

  always_comb begin
    state_next       = state;
    icache_get_ready = 1'b0;
    mem_req          = 1'b0;
    wr_ready         = 1'b0;
    if (!rst_in && rdy_in) begin
      unique case (state)
        S_FETCH: begin
          icache_get_ready = out_free && !flush_in;
          if (icache_get_ready && !hit) state_next = S_MISS;
        end
        S_MISS: begin
          mem_req = (iss < asm_need);
          if (asm_last) state_next = S_FILL;
        end
        S_FILL: begin
          wr_ready   = !flush_in;
          state_next = S_FETCH;
        end
        S_DRAIN: state_next = S_FETCH;
        default: state_next = S_FETCH;
      endcase
      // A byte still in flight after the redirect must be swallowed before refetching.
      if (flush_in)
        state_next = (grant || ((state == S_MISS) && (iss > asm_rcv))) ? S_DRAIN : S_FETCH;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= S_FETCH;
    else if (rdy_in) state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc         <= RESET_PC;
      iss        <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_is_c  <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc         <= {flush_pc[31:1], 1'b0};
        iss        <= '0;
        inst_valid <= 1'b0;
      end else begin
        if (lookup_miss) iss <= '0;
        else if (grant)  iss <= iss + 3'd1;
        if (lookup_hit) begin
          inst_valid <= 1'b1;
          inst_out   <= icache_get_inst;
          inst_pc    <= pc;
          inst_is_c  <= icache_get_is_c;
          pc         <= pc_step(pc, icache_get_is_c ? INST_LEN_C : INST_LEN_W);
        end else if (inst_ready) begin
          inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural cache and byte memory,
// scoreboard queues for decoder outputs and cache writes.
module tb_ifetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, inst_ready;
  logic [31:0] flush_pc;
  logic        icache_get_ready, hit, icache_get_is_c;
  logic [31:0] icache_get_addr, icache_get_inst;
  logic        wr_ready, wr_is_c;
  logic [31:0] wr_addr, wr_inst;
  logic        mem_req, mem_grant;
  logic        mem_dvalid = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [31:0] mem_addr;
  logic        inst_valid, inst_is_c;
  logic [31:0] inst_out, inst_pc;

  ifetch_unit #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .flush_pc(flush_pc),
    .icache_get_ready(icache_get_ready), .icache_get_addr(icache_get_addr), .hit(hit),
    .icache_get_inst(icache_get_inst), .icache_get_is_c(icache_get_is_c),
    .wr_ready(wr_ready), .wr_is_c(wr_is_c), .wr_addr(wr_addr), .wr_inst(wr_inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant), .mem_dvalid(mem_dvalid),
    .mem_din(mem_din), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_is_c(inst_is_c)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction cache model: small fully associative table, entry 0 preloaded on reset.
  logic [31:0] c_addr [8];
  logic [31:0] c_inst [8];
  logic        c_isc  [8];
  logic [7:0]  c_vld = '0;
  logic [2:0]  c_n = '0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      c_vld     <= 8'b0000_0001;
      c_addr[0] <= 32'h0;
      c_inst[0] <= 32'h00500093;
      c_isc[0]  <= 1'b0;
      c_n       <= 3'd1;
    end else if (wr_ready) begin
      c_addr[c_n] <= wr_addr;
      c_inst[c_n] <= wr_inst;
      c_isc[c_n]  <= wr_is_c;
      c_vld[c_n]  <= 1'b1;
      c_n         <= c_n + 3'd1;
    end
  end

  always_comb begin
    hit             = 1'b0;
    icache_get_inst = '0;
    icache_get_is_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c_vld[i] && (c_addr[i] == icache_get_addr)) begin
        hit             = 1'b1;
        icache_get_inst = c_inst[i];
        icache_get_is_c = c_isc[i];
      end
    end
  end

  // Byte memory behind an always-granting arbiter, frozen by the same rdy_in.
  logic [7:0] mem_bytes [logic [31:0]];
  assign mem_grant = mem_req;

  always @(posedge clk_in) begin
    if (rst_in) begin
      mem_dvalid <= 1'b0;
      mem_din    <= 8'h00;
    end else if (rdy_in) begin
      mem_dvalid <= mem_grant;
      mem_din    <= mem_bytes.exists(mem_addr) ? mem_bytes[mem_addr] : 8'h00;
    end
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
    int          cyc;
  } dec_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        is_c;
  } wr_exp_t;

  dec_exp_t dec_q [$];
  wr_exp_t  wr_q  [$];
  dec_exp_t de;
  wr_exp_t  we;

  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && inst_valid && inst_ready) begin
      n_cmp++;
      if (dec_q.size() == 0) begin
        n_bad++;
        $display("FAIL dec_unexpected: got inst %h pc %h, expected no output", inst_out, inst_pc);
      end else begin
        de = dec_q.pop_front();
        if ({inst_out, inst_pc, inst_is_c} !== {de.inst, de.pc, de.is_c}) begin
          n_bad++;
          $display("FAIL dec_data: got %h/%h/%b expected %h/%h/%b",
                   inst_out, inst_pc, inst_is_c, de.inst, de.pc, de.is_c);
        end
        n_cmp++;
        if (cyc != de.cyc) begin
          n_bad++;
          $display("FAIL dec_latency pc %h: got cycle %0d expected %0d", de.pc, cyc, de.cyc);
        end
      end
    end
    if (!rst_in && wr_ready) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got write addr %h inst %h, expected none", wr_addr, wr_inst);
      end else begin
        we = wr_q.pop_front();
        if ({wr_addr, wr_inst, wr_is_c} !== {we.addr, we.inst, we.is_c}) begin
          n_bad++;
          $display("FAIL wr_data: got %h/%h/%b expected %h/%h/%b",
                   wr_addr, wr_inst, wr_is_c, we.addr, we.inst, we.is_c);
        end
      end
    end
  end

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = '0; inst_ready = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if ({inst_valid, inst_is_c, icache_get_ready, mem_req, wr_ready, wr_is_c} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000000",
               {inst_valid, inst_is_c, icache_get_ready, mem_req, wr_ready, wr_is_c});
    end
    n_cmp++;
    if ({inst_out, inst_pc, mem_addr, wr_addr, wr_inst} !== 160'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h %h %h expected all zero",
               inst_out, inst_pc, mem_addr, wr_addr, wr_inst);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if ({icache_get_ready, icache_get_addr} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_lookup: got rdy %b addr %h expected 1 00000000", icache_get_ready, icache_get_addr);
    end
    @(negedge clk_in);
    n_cmp++;
    if ({inst_valid, inst_out, inst_pc, inst_is_c} !== {1'b1, 32'h00500093, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_first_inst: got %b %h %h %b expected 1 00500093 00000000 0",
               inst_valid, inst_out, inst_pc, inst_is_c);
    end
    n_cmp++;
    if ({icache_get_ready, icache_get_addr} !== {1'b0, 32'h4}) begin
      n_bad++;
      $display("FAIL reset_next_pc: got rdy %b addr %h expected 0 00000004", icache_get_ready, icache_get_addr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if ({inst_valid, inst_out, inst_pc} !== {1'b1, 32'h00500093, 32'h0}) begin
        n_bad++;
        $display("FAIL stall_hold %0d: got %b %h %h expected 1 00500093 00000000", i, inst_valid, inst_out, inst_pc);
      end
      n_cmp++;
      if ({icache_get_ready, icache_get_addr} !== {1'b0, 32'h4}) begin
        n_bad++;
        $display("FAIL stall_lookup %0d: got rdy %b addr %h expected 0 00000004", i, icache_get_ready, icache_get_addr);
      end
    end
  endtask

  task automatic test_miss_word();
    logic [31:0] addrs [$];
    bit          found = 1'b0;
    @(posedge clk_in); #1;
    flush_in = 1'b1; flush_pc = 32'h100;
    @(posedge clk_in); #1;
    flush_in = 1'b0; inst_ready = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if ({icache_get_ready, icache_get_addr} !== {1'b1, 32'h100}) begin
      n_bad++;
      $display("FAIL word_lookup: got rdy %b addr %h expected 1 00000100", icache_get_ready, icache_get_addr);
    end
    wr_q.push_back('{32'h100, 32'h00A00513, 1'b0});
    dec_q.push_back('{32'h00A00513, 32'h100, 1'b0, cyc + 8});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (mem_req) addrs.push_back(mem_addr);
      if (inst_valid && inst_pc == 32'h100) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || addrs.size() != 4) begin
      n_bad++;
      $display("FAIL word_requests: got found %b count %0d expected 1 4", found, addrs.size());
    end
    for (int k = 0; k < addrs.size() && k < 4; k++) begin
      n_cmp++;
      if (addrs[k] !== 32'h100 + k) begin
        n_bad++;
        $display("FAIL word_mem_addr %0d: got %h expected %h", k, addrs[k], 32'h100 + k);
      end
    end
    n_cmp++;
    if ({icache_get_ready, icache_get_addr} !== {1'b1, 32'h104}) begin
      n_bad++;
      $display("FAIL word_next_pc: got rdy %b addr %h expected 1 00000104", icache_get_ready, icache_get_addr);
    end
  endtask

  task automatic test_miss_compressed();
    logic [31:0] addrs [$];
    bit          found = 1'b0;
    wr_q.push_back('{32'h104, 32'h00004505, 1'b1});
    dec_q.push_back('{32'h00004505, 32'h104, 1'b1, cyc + 6});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (mem_req) addrs.push_back(mem_addr);
      if (inst_valid && inst_pc == 32'h104) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || addrs.size() != 2) begin
      n_bad++;
      $display("FAIL rvc_requests: got found %b count %0d expected 1 2", found, addrs.size());
    end
    for (int k = 0; k < addrs.size() && k < 2; k++) begin
      n_cmp++;
      if (addrs[k] !== 32'h104 + k) begin
        n_bad++;
        $display("FAIL rvc_mem_addr %0d: got %h expected %h", k, addrs[k], 32'h104 + k);
      end
    end
    n_cmp++;
    if (icache_get_addr !== 32'h106) begin
      n_bad++;
      $display("FAIL rvc_next_pc: got %h expected 00000106", icache_get_addr);
    end
  endtask

  task automatic test_flush_drain();
    @(negedge clk_in);
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h106}) begin
      n_bad++;
      $display("FAIL drain_miss_start: got req %b addr %h expected 1 00000106", mem_req, mem_addr);
    end
    @(posedge clk_in); #1;
    flush_in = 1'b1; flush_pc = 32'h201;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if ({mem_req, icache_get_ready, wr_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL drain_quiet: got req/lookup/wr %b expected 000", {mem_req, icache_get_ready, wr_ready});
    end
    @(negedge clk_in);
    n_cmp++;
    if ({icache_get_ready, icache_get_addr} !== {1'b1, 32'h200}) begin
      n_bad++;
      $display("FAIL drain_refetch: got rdy %b addr %h expected 1 00000200", icache_get_ready, icache_get_addr);
    end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] addrs [$];
    bit          found = 1'b0;
    wr_q.push_back('{32'h200, 32'h00108093, 1'b0});
    dec_q.push_back('{32'h00108093, 32'h200, 1'b0, cyc + 11});
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_in); #1;
      rdy_in = (i < 3) || (i > 5);
      @(negedge clk_in);
      if (!rdy_in) begin
        n_cmp++;
        if ({mem_req, icache_get_ready, wr_ready} !== 3'b000) begin
          n_bad++;
          $display("FAIL rdy_gate %0d: got req/lookup/wr %b expected 000", i, {mem_req, icache_get_ready, wr_ready});
        end
      end
      if (mem_req) addrs.push_back(mem_addr);
      if (inst_valid && inst_pc == 32'h200) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || addrs.size() != 4) begin
      n_bad++;
      $display("FAIL rdy_requests: got found %b count %0d expected 1 4", found, addrs.size());
    end
    for (int k = 0; k < addrs.size() && k < 4; k++) begin
      n_cmp++;
      if (addrs[k] !== 32'h200 + k) begin
        n_bad++;
        $display("FAIL rdy_mem_addr %0d: got %h expected %h", k, addrs[k], 32'h200 + k);
      end
    end
  endtask

  task automatic test_flush_hit();
    bit found = 1'b0;
    @(posedge clk_in); #1;
    flush_in = 1'b1; flush_pc = 32'h0; inst_ready = 1'b0;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (inst_valid) begin found = 1'b1; break; end
    end
    n_cmp++;
    if ({found, inst_out, inst_pc} !== {1'b1, 32'h00500093, 32'h0}) begin
      n_bad++;
      $display("FAIL flush_hit: got %b %h %h expected 1 00500093 00000000", found, inst_out, inst_pc);
    end
    n_cmp++;
    if (dec_q.size() != 0 || wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drained: got %0d dec / %0d wr pending expected 0 / 0", dec_q.size(), wr_q.size());
    end
  endtask

  initial begin
    mem_bytes[32'h100] = 8'h13; mem_bytes[32'h101] = 8'h05;
    mem_bytes[32'h102] = 8'hA0; mem_bytes[32'h103] = 8'h00;
    mem_bytes[32'h104] = 8'h05; mem_bytes[32'h105] = 8'h45;
    mem_bytes[32'h106] = 8'h13; mem_bytes[32'h107] = 8'h00;
    mem_bytes[32'h200] = 8'h93; mem_bytes[32'h201] = 8'h80;
    mem_bytes[32'h202] = 8'h10; mem_bytes[32'h203] = 8'h00;
    test_reset();
    test_stall();
    test_miss_word();
    test_miss_compressed();
    test_flush_drain();
    test_rdy_stall();
    test_flush_hit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
